// File: rtl/pe_collector_pkg.sv
// Shared types and helpers for the PE column stream collector.
// Default geometry and the legal-configuration check used at job start.
package pe_collector_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int DEF_NUM_COL    = 7;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int COL_W          = $clog2(DEF_NUM_COL);
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

  // A job needs at least one active column, no more than exist, and at least one row.
  function automatic logic cfg_legal(input logic [31:0] num_col,
                                     input logic [31:0] rows,
                                     input logic [31:0] max_col);
    return (num_col != 32'd0) && (num_col <= max_col) && (rows != 32'd0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count and synchronous clear.
// Read data is the head entry; a write to a full FIFO is taken only if it pops too.
module sync_fifo
  import pe_collector_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  assign empty   = (r_count == '0);
  assign full    = (r_count == (PW+1)'(DEPTH));
  assign w_do_rd = rd_en && !empty;
  assign w_do_wr = wr_en && (!full || w_do_rd);
  assign rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_stream_collector.sv
// Collects per-column PE results into FIFOs and drains them in strict column
// order onto one valid/ready stream with row framing, overflow flags and done.
module pe_stream_collector
  import pe_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = 16,
  localparam int NC_W      = $clog2(NUM_COL + 1),
  localparam int LCOL_W    = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [NC_W-1:0]       cfg_num_col,
  input  logic [CNT_WIDTH-1:0]  cfg_rows,
  input  logic [NUM_COL-1:0]    in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [NUM_COL],
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [LCOL_W-1:0]     m_col,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [NUM_COL-1:0]    overflow
);

  state_e                r_state;
  logic [NC_W-1:0]       r_num_col;
  logic [CNT_WIDTH-1:0]  r_rows;
  logic [LCOL_W-1:0]     r_col_ptr;
  logic [CNT_WIDTH-1:0]  r_row_cnt;
  logic                  r_done;
  logic                  r_cfg_err;
  logic [NUM_COL-1:0]    r_overflow;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [LCOL_W-1:0]     r_m_col;
  logic                  r_m_last;

  logic                  w_active;
  logic                  w_cfg_ok;
  logic                  w_clr;
  logic                  w_out_free;
  logic                  w_pop;
  logic                  w_ptr_last;
  logic                  w_row_last;
  logic [NUM_COL-1:0]    w_wr_en;
  logic [NUM_COL-1:0]    w_rd_en;
  logic [NUM_COL-1:0]    w_full;
  logic [NUM_COL-1:0]    w_empty;
  logic [NUM_COL-1:0]    w_ovf_set;
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_COL];

  assign w_active   = (r_state != IDLE);
  assign w_cfg_ok   = cfg_legal(32'(cfg_num_col), 32'(cfg_rows), 32'(NUM_COL));
  assign w_clr      = (r_state == IDLE) && start && w_cfg_ok;
  assign w_out_free = !r_m_valid || m_ready;
  // No skipping: an empty FIFO at the pointer stalls the whole stream.
  assign w_pop      = (r_state == RUN) && !w_empty[r_col_ptr] && w_out_free;
  assign w_ptr_last = (NC_W'(r_col_ptr) == r_num_col - 1'b1);
  assign w_row_last = (r_row_cnt == r_rows - CNT_WIDTH'(1));

  for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_col
    localparam logic [NC_W-1:0]   IDX_N = NC_W'(gi);
    localparam logic [LCOL_W-1:0] IDX_C = LCOL_W'(gi);

    assign w_wr_en[gi]   = in_valid[gi] && (IDX_N < r_num_col) && w_active;
    assign w_rd_en[gi]   = w_pop && (r_col_ptr == IDX_C);
    assign w_ovf_set[gi] = w_wr_en[gi] && w_full[gi] && !w_rd_en[gi];

    sync_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (w_clr),
      .wr_en   (w_wr_en[gi]),
      .wr_data (in_data[gi]),
      .rd_en   (w_rd_en[gi]),
      .rd_data (w_rd_data[gi]),
      .full    (w_full[gi]),
      .empty   (w_empty[gi])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_num_col  <= '0;
      r_rows     <= '0;
      r_col_ptr  <= '0;
      r_row_cnt  <= '0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_overflow <= '0;
    end else begin
      r_done     <= 1'b0;
      r_overflow <= r_overflow | w_ovf_set;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_num_col  <= cfg_num_col;
              r_rows     <= cfg_rows;
              r_col_ptr  <= '0;
              r_row_cnt  <= '0;
              r_cfg_err  <= 1'b0;
              r_overflow <= '0;
              r_state    <= RUN;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_pop) begin
            if (w_ptr_last) begin
              r_col_ptr <= '0;
              r_row_cnt <= r_row_cnt + 1'b1;
              if (w_row_last) begin
                r_state <= FLUSH;
              end
            end else begin
              r_col_ptr <= r_col_ptr + 1'b1;
            end
          end
        end
        FLUSH: begin
          // The output register empties on this edge, so the job is complete.
          if (w_out_free) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_col   <= '0;
      r_m_last  <= 1'b0;
    end else if (w_out_free) begin
      r_m_valid <= w_pop;
      if (w_pop) begin
        r_m_data <= w_rd_data[r_col_ptr];
        r_m_col  <= r_col_ptr;
        r_m_last <= w_ptr_last;
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_data   = r_m_data;
  assign m_col    = r_m_col;
  assign m_last   = r_m_last;
  assign busy     = w_active;
  assign done     = r_done;
  assign cfg_err  = r_cfg_err;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_pe_stream_collector.sv
// Self-checking bench: directed scenarios plus random jobs, compared against a
// row-major queue of expected words built from what each column wrote.
module tb_pe_stream_collector;

  localparam int DW   = 64;
  localparam int NC   = 7;
  localparam int FD   = 16;
  localparam int CW   = 16;
  localparam int NCW  = $clog2(NC + 1);
  localparam int COLW = $clog2(NC);

  typedef struct {
    logic [DW-1:0] d;
    int            c;
    bit            l;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic            start;
  logic [NCW-1:0]  cfg_num_col;
  logic [CW-1:0]   cfg_rows;
  logic [NC-1:0]   in_valid;
  logic [DW-1:0]   in_data [NC];
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [COLW-1:0] m_col;
  logic            m_last;
  logic            busy;
  logic            done;
  logic            cfg_err;
  logic [NC-1:0]   overflow;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;
  exp_t exp_q[$];

  pe_stream_collector #(
    .DATA_WIDTH (DW),
    .NUM_COL    (NC),
    .FIFO_DEPTH (FD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .cfg_num_col (cfg_num_col),
    .cfg_rows    (cfg_rows),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_col       (m_col),
    .m_last      (m_last),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One clock: score an accepted word, then check hold-while-stalled and done.
  task automatic tick();
    logic            acc, hold, fin, hl;
    logic [DW-1:0]   hd;
    logic [COLW-1:0] hc;
    exp_t            e;
    acc  = m_valid && m_ready;
    hold = m_valid && !m_ready;
    fin  = 1'b0;
    hd   = m_data;
    hc   = m_col;
    hl   = m_last;
    if (acc) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", 64'(m_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("word_data", m_data, e.d);
        chk("word_col", 64'(m_col), 64'(e.c));
        chk("word_last", 64'(m_last), 64'(e.l));
        n_acc++;
        fin = (exp_q.size() == 0);
      end
    end
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 64'(m_valid), 64'd1);
      chk("hold_data", m_data, hd);
      chk("hold_col", 64'(m_col), 64'(hc));
      chk("hold_last", 64'(m_last), 64'(hl));
    end
    chk("done_pulse", 64'(done), 64'(fin));
  endtask

  task automatic do_start(input int nc, input int rows);
    cfg_num_col = NCW'(nc);
    cfg_rows    = CW'(rows);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic drain(input bit toggle);
    int budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      m_ready = toggle ? !m_ready : 1'b1;
      tick();
      budget++;
    end
    m_ready = 1'b1;
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    chk("idle_after_drain", 64'(busy), 64'd0);
  endtask

  task automatic push_exp(input logic [DW-1:0] d, input int c, input int nc);
    exp_t e;
    e.d = d;
    e.c = c;
    e.l = (c == nc - 1);
    exp_q.push_back(e);
  endtask

  // Each column writes exactly `rows` words at random times; at most FD per job, so none can drop.
  task automatic run_data(input int nc, input int rows, input int pct);
    logic [DW-1:0] wd [NC][FD];
    int            wi [NC];
    int            budget = 0;
    for (int c = 0; c < NC; c++) begin
      wi[c] = 0;
      for (int r = 0; r < FD; r++) wd[c][r] = rnd64();
    end
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < nc; c++) push_exp(wd[c][r], c, nc);
    while (exp_q.size() != 0 && budget < 4000) begin
      in_valid = '0;
      for (int c = 0; c < nc; c++) begin
        if (wi[c] < rows && $urandom_range(1) == 1) begin
          in_valid[c] = 1'b1;
          in_data[c]  = wd[c][wi[c]];
          wi[c]++;
        end
      end
      m_ready = (int'($urandom_range(99)) < pct);
      tick();
      budget++;
    end
    in_valid = '0;
    m_ready  = 1'b1;
    chk("job_drained", 64'(exp_q.size()), 64'd0);
    chk("idle_after_job", 64'(busy), 64'd0);
    chk("no_overflow", 64'(overflow), 64'd0);
  endtask

  task automatic basic_job(input bit toggle);
    logic [DW-1:0] v [2][3];
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        v[r][c] = 64'hC011_EC70_0000_0000 | 64'((int'(toggle) << 16) | (r << 8) | c);
    do_start(3, 2);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_cfg_err", 64'(cfg_err), 64'd0);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) push_exp(v[r][c], c, 3);
    m_ready  = !toggle;
    in_valid = 7'b0000111;
    for (int c = 0; c < 3; c++) in_data[c] = v[0][c];
    tick();
    chk("latency_t1_valid", 64'(m_valid), 64'd0);
    for (int c = 0; c < 3; c++) in_data[c] = v[1][c];
    if (toggle) m_ready = !m_ready;
    tick();
    chk("latency_t2_valid", 64'(m_valid), 64'd1);
    in_valid = '0;
    drain(toggle);
  endtask

  initial begin
    logic [DW-1:0] w0 [FD];
    logic [DW-1:0] w1 [FD+1];
    int            base;
    int            budget;
    int            nc, rows;

    rstn        = 1'b0;
    start       = 1'b0;
    cfg_num_col = '0;
    cfg_rows    = '0;
    in_valid    = '0;
    m_ready     = 1'b1;
    for (int c = 0; c < NC; c++) in_data[c] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_col", 64'(m_col), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rstn = 1'b1;
    tick();

    // Basic order, then the same job under alternating backpressure.
    basic_job(1'b0);
    basic_job(1'b1);

    // Out-of-order arrival: column 0 shows up last and gates the stream.
    do_start(3, 1);
    for (int c = 0; c < 3; c++) begin
      w0[c] = rnd64();
      push_exp(w0[c], c, 3);
    end
    in_valid = 7'b0000100; in_data[2] = w0[2]; tick();
    chk("ooo_wait1", 64'(m_valid), 64'd0);
    in_valid = 7'b0000010; in_data[1] = w0[1]; tick();
    chk("ooo_wait2", 64'(m_valid), 64'd0);
    in_valid = '0; tick();
    chk("ooo_wait3", 64'(m_valid), 64'd0);
    in_valid = 7'b0000001; in_data[0] = w0[0]; tick();
    in_valid = '0;
    drain(1'b0);

    // Overflow: column 1 writes one more word than fits while nothing drains.
    do_start(2, FD);
    m_ready = 1'b0;
    for (int k = 0; k <= FD; k++) begin
      w1[k]       = rnd64();
      in_valid    = 7'b0000010;
      in_data[1]  = w1[k];
      tick();
      if (k == FD - 1) chk("ovf_at_depth", 64'(overflow), 64'd0);
    end
    in_valid = '0;
    chk("ovf_set", 64'(overflow), 64'd2);
    chk("ovf_no_output", 64'(m_valid), 64'd0);
    for (int r = 0; r < FD; r++) begin
      w0[r] = rnd64();
      push_exp(w0[r], 0, 2);
      push_exp(w1[r], 1, 2);
    end
    m_ready = 1'b1;
    for (int r = 0; r < FD; r++) begin
      in_valid   = 7'b0000001;
      in_data[0] = w0[r];
      tick();
    end
    in_valid = '0;
    drain(1'b0);
    chk("ovf_sticky", 64'(overflow), 64'd2);
    do_start(3, 4);
    chk("ovf_cleared", 64'(overflow), 64'd0);
    run_data(3, 4, 70);

    // Illegal configurations (8 truncates to 0 in the 3-bit field).
    do_start(0, 4);
    chk("bad_nc0_err", 64'(cfg_err), 64'd1);
    chk("bad_nc0_busy", 64'(busy), 64'd0);
    do_start(8, 4);
    chk("bad_nc8_err", 64'(cfg_err), 64'd1);
    chk("bad_nc8_busy", 64'(busy), 64'd0);
    do_start(3, 0);
    chk("bad_rows0_err", 64'(cfg_err), 64'd1);
    chk("bad_rows0_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      in_valid = '1;
      for (int c = 0; c < NC; c++) in_data[c] = rnd64();
      tick();
      chk("idle_no_output", 64'(m_valid), 64'd0);
    end
    in_valid = '0;
    do_start(NC, FD);
    chk("legal_clears_err", 64'(cfg_err), 64'd0);
    run_data(NC, FD, 100);
    do_start(1, 1);
    run_data(1, 1, 50);

    // Reset in the middle of a 3x2 job, after two words have gone out.
    do_start(3, 2);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        w0[r*3+c] = rnd64();
        push_exp(w0[r*3+c], c, 3);
      end
    m_ready  = 1'b1;
    in_valid = 7'b0000111;
    for (int c = 0; c < 3; c++) in_data[c] = w0[c];
    tick();
    for (int c = 0; c < 3; c++) in_data[c] = w0[3+c];
    tick();
    in_valid = '0;
    base   = n_acc;
    budget = 0;
    while (n_acc - base < 2 && budget < 50) begin
      tick();
      budget++;
    end
    chk("mid_two_accepted", 64'(n_acc - base), 64'd2);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_m_data", m_data, 64'd0);
    chk("mid_rst_m_last", 64'(m_last), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rstn = 1'b1;
    tick();
    do_start(3, 2);
    run_data(3, 2, 60);

    // Random jobs across column counts, row counts and ready rates.
    for (int j = 0; j < 6; j++) begin
      nc   = int'($urandom_range(NC, 1));
      rows = int'($urandom_range(FD, 1));
      do_start(nc, rows);
      chk("rand_start_busy", 64'(busy), 64'd1);
      chk("rand_cfg_err", 64'(cfg_err), 64'd0);
      run_data(nc, rows, int'($urandom_range(100, 30)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
